// File: rtl/gpio_ctrl.sv
// GPIO controller on the emesh register bus: atomic output ops, per-pin debounce,
// and edge/level interrupts with a write-1-to-clear latch.
module gpio_ctrl #(
  parameter int N  = 24,
  parameter int AW = 32,
  parameter int PW = 2*AW+40,
  parameter int ID = 0,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          reg_access,
  input  logic [PW-1:0] reg_packet,
  input  logic [N-1:0]  gpio_in,
  output logic [31:0]   reg_rdata,
  output logic [N-1:0]  gpio_out,
  output logic [N-1:0]  gpio_en,
  output logic          gpio_irq,
  output logic [N-1:0]  gpio_ilat
);

  localparam logic [3:0] A_DIR   = 4'd0;
  localparam logic [3:0] A_OUT   = 4'd1;
  localparam logic [3:0] A_SET   = 4'd2;
  localparam logic [3:0] A_CLR   = 4'd3;
  localparam logic [3:0] A_TOG   = 4'd4;
  localparam logic [3:0] A_IN    = 4'd5;
  localparam logic [3:0] A_IMASK = 4'd6;
  localparam logic [3:0] A_ITYPE = 4'd7;
  localparam logic [3:0] A_IPOL  = 4'd8;
  localparam logic [3:0] A_ILAT  = 4'd9;
  localparam logic [3:0] A_DBEN  = 4'd10;
  localparam logic [3:0] A_DBCNT = 4'd11;

  logic [AW-1:0] dstaddr;
  logic [31:0]   wdata;
  logic [N-1:0]  wd;
  logic [3:0]    idx;
  logic          hit, wr, rd, clr_cnt;
  logic          unused_pkt;

  logic [N-1:0]  dir, out_r, imask, itype, ipol, ilat, dben;
  logic [DW-1:0] dbcnt;
  logic [N-1:0]  sync1, sync, filt, filt_d;
  logic [DW-1:0] cnt [N];
  logic [N-1:0]  irq_set, w1c;
  logic [31:0]   rd_mux;

  assign dstaddr    = reg_packet[AW+7:8];
  assign wdata      = reg_packet[AW+39:AW+8];
  assign wd         = wdata[N-1:0];
  assign idx        = dstaddr[6:3];
  assign hit        = reg_access && (dstaddr[10:8] == 3'(ID));
  assign wr         = hit && reg_packet[0];
  assign rd         = hit && !reg_packet[0];
  assign clr_cnt    = wr && (idx == A_DBEN || idx == A_DBCNT);
  assign unused_pkt = ^reg_packet;

  // Edge mode compares against the previous filtered value; level mode fires every cycle.
  assign irq_set = (itype & ((ipol & filt & ~filt_d) | (~ipol & ~filt & filt_d)))
                 | (~itype & ~(filt ^ ipol));
  assign w1c     = (wr && idx == A_ILAT) ? wd : '0;

  always_comb begin
    rd_mux = '0;
    case (idx)
      A_DIR:   rd_mux = 32'(dir);
      A_OUT:   rd_mux = 32'(out_r);
      A_IN:    rd_mux = 32'(filt);
      A_IMASK: rd_mux = 32'(imask);
      A_ITYPE: rd_mux = 32'(itype);
      A_IPOL:  rd_mux = 32'(ipol);
      A_ILAT:  rd_mux = 32'(ilat);
      A_DBEN:  rd_mux = 32'(dben);
      A_DBCNT: rd_mux = 32'(dbcnt);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      dir       <= '0;
      out_r     <= '0;
      imask     <= '0;
      itype     <= '0;
      ipol      <= '0;
      ilat      <= '0;
      dben      <= '0;
      dbcnt     <= '0;
      reg_rdata <= '0;
    end else begin
      // set is OR-ed in after the clear so a same-cycle event survives W1C
      ilat <= (ilat & ~w1c) | irq_set;
      if (rd) reg_rdata <= rd_mux;
      if (wr) begin
        case (idx)
          A_DIR:   dir   <= wd;
          A_OUT:   out_r <= wd;
          A_SET:   out_r <= out_r | wd;
          A_CLR:   out_r <= out_r & ~wd;
          A_TOG:   out_r <= out_r ^ wd;
          A_IMASK: imask <= wd;
          A_ITYPE: itype <= wd;
          A_IPOL:  ipol  <= wd;
          A_DBEN:  dben  <= wd;
          A_DBCNT: dbcnt <= wdata[DW-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1  <= '0;
      sync   <= '0;
      filt   <= '0;
      filt_d <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      sync1  <= gpio_in;
      sync   <= sync1;
      filt_d <= filt;
      for (int i = 0; i < N; i++) begin
        if (!dben[i]) begin
          filt[i] <= sync[i];
          cnt[i]  <= '0;
        end else if (clr_cnt || sync[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == dbcnt) begin
          filt[i] <= sync[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + DW'(1);
        end
      end
    end
  end

  assign gpio_out  = out_r;
  assign gpio_en   = dir;
  assign gpio_ilat = ilat;
  assign gpio_irq  = |(ilat & imask);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: output ops, readback/ID filter, interrupts, debounce, reset.
module tb_gpio_ctrl;
  localparam int N  = 24;
  localparam int AW = 32;
  localparam int PW = 2*AW+40;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          nreset;
  logic          reg_access;
  logic [PW-1:0] reg_packet;
  logic [N-1:0]  gpio_in;
  logic [31:0]   reg_rdata;
  logic [N-1:0]  gpio_out, gpio_en, gpio_ilat;
  logic          gpio_irq;

  int n_err = 0;
  int n_chk = 0;
  logic [31:0] v;

  gpio_ctrl #(.N(N), .AW(AW), .PW(PW), .ID(0), .DW(DW)) dut (
    .clk(clk), .nreset(nreset), .reg_access(reg_access), .reg_packet(reg_packet),
    .gpio_in(gpio_in), .reg_rdata(reg_rdata), .gpio_out(gpio_out), .gpio_en(gpio_en),
    .gpio_irq(gpio_irq), .gpio_ilat(gpio_ilat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w, input logic [3:0] idx, input logic [31:0] d,
                       input logic [2:0] id);
    logic [31:0] dst;
    dst = {21'b0, id, 1'b0, idx, 3'b0};
    reg_packet = '0;
    reg_packet[0] = w;
    reg_packet[2:1] = 2'b10;
    reg_packet[AW+7:8] = dst;
    reg_packet[AW+39:AW+8] = d;
    reg_packet[PW-1:AW+40] = 32'hDEAD_BEEF;
    reg_access = 1'b1;
  endtask

  task automatic bus(input bit w, input logic [3:0] idx, input logic [31:0] d,
                     input logic [2:0] id);
    @(negedge clk);
    drive(w, idx, d, id);
    @(negedge clk);
    reg_access = 1'b0;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] d);
    bus(1'b1, idx, d, 3'd0);
  endtask

  task automatic rd(input logic [3:0] idx, output logic [31:0] d);
    bus(1'b0, idx, 32'h0, 3'd0);
    d = reg_rdata;
  endtask

  initial begin
    nreset = 1'b0;
    reg_access = 1'b0;
    reg_packet = '0;
    gpio_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(gpio_out), 32'h0);
    chk("rst_en", 32'(gpio_en), 32'h0);
    chk("rst_irq", 32'(gpio_irq), 32'h0);
    chk("rst_rdata", reg_rdata, 32'h0);
    nreset = 1'b1;

    // atomic output operations
    wr(4'd1, 32'h000F0F); chk("out_wr", 32'(gpio_out), 32'h000F0F);
    wr(4'd2, 32'hF00000); chk("out_set", 32'(gpio_out), 32'hF00F0F);
    wr(4'd3, 32'h00000F); chk("out_clr", 32'(gpio_out), 32'hF00F00);
    wr(4'd4, 32'h0000FF); chk("out_tog", 32'(gpio_out), 32'hF00FFF);
    wr(4'd2, 32'hFF000000); chk("out_hi_bits", 32'(gpio_out), 32'hF00FFF);
    wr(4'd0, 32'hFFFFFFFF); chk("dir", 32'(gpio_en), 32'hFFFFFF);
    rd(4'd1, v); chk("rd_out", v, 32'hF00FFF);

    // readback and id filter
    gpio_in = 24'h00A5A5;
    repeat (4) @(negedge clk);
    rd(4'd5, v); chk("rd_in", v, 32'h00A5A5);
    rd(4'd0, v); chk("rd_dir", v, 32'hFFFFFF);
    bus(1'b1, 4'd1, 32'h0, 3'd1); chk("id_wr", 32'(gpio_out), 32'hF00FFF);
    bus(1'b0, 4'd5, 32'h0, 3'd1); chk("id_rd", reg_rdata, 32'hFFFFFF);
    rd(4'd2, v); chk("rd_wo", v, 32'h0);
    rd(4'd13, v); chk("rd_rsvd", v, 32'h0);

    // edge interrupt on pin 0, rising
    gpio_in = '0;
    repeat (5) @(negedge clk);
    wr(4'd7, 32'hFFFFFF);
    wr(4'd8, 32'hFFFFFF);
    wr(4'd6, 32'h1);
    wr(4'd9, 32'hFFFFFF);
    chk("edge_clr", 32'(gpio_ilat), 32'h0);
    chk("edge_clr_irq", 32'(gpio_irq), 32'h0);
    gpio_in = 24'h1;
    repeat (3) @(negedge clk);
    chk("edge_lat3", 32'(gpio_ilat), 32'h0);
    @(negedge clk);
    chk("edge_lat4", 32'(gpio_ilat), 32'h1);
    chk("edge_irq", 32'(gpio_irq), 32'h1);
    wr(4'd9, 32'h1);
    chk("edge_w1c", 32'(gpio_ilat), 32'h0);
    chk("edge_w1c_irq", 32'(gpio_irq), 32'h0);
    gpio_in = '0;
    repeat (6) @(negedge clk);
    chk("edge_fall", 32'(gpio_ilat), 32'h0);

    // level low on pin 3 only; W1C collides with an active set
    wr(4'd7, 32'h0);
    wr(4'd8, 32'hFFFFF7);
    wr(4'd9, 32'hFFFFFF);
    chk("lvl_w1c", 32'(gpio_ilat), 32'h000008);
    wr(4'd6, 32'h8); chk("lvl_irq", 32'(gpio_irq), 32'h1);
    wr(4'd6, 32'h0); chk("lvl_mask", 32'(gpio_irq), 32'h0);
    chk("lvl_lat", 32'(gpio_ilat), 32'h000008);

    // debounce on pin 1, threshold 4
    wr(4'd10, 32'h2);
    wr(4'd11, 32'h4);
    rd(4'd11, v); chk("rd_dbcnt", v, 32'h4);
    gpio_in = 24'h2;
    repeat (3) @(negedge clk);
    gpio_in = '0;
    repeat (10) @(negedge clk);
    rd(4'd5, v); chk("db_glitch_in", v, 32'h0);
    chk("db_glitch_lat", 32'(gpio_ilat), 32'h000008);
    gpio_in = 24'h2;
    repeat (6) @(negedge clk);
    drive(1'b0, 4'd5, 32'h0, 3'd0);
    @(negedge clk);
    chk("db_in_e7", reg_rdata, 32'h0);
    chk("db_lat_e7", 32'(gpio_ilat), 32'h000008);
    @(negedge clk);
    reg_access = 1'b0;
    chk("db_in_e8", reg_rdata, 32'h2);
    chk("db_lat_e8", 32'(gpio_ilat), 32'h00000A);

    // asynchronous reset in the middle of a write
    wr(4'd1, 32'hFFFFFF); chk("pre_rst_out", 32'(gpio_out), 32'hFFFFFF);
    @(negedge clk);
    drive(1'b1, 4'd4, 32'hFFFFFF, 3'd0);
    #2 nreset = 1'b0;
    gpio_in = '0;
    #1;
    chk("arst_out", 32'(gpio_out), 32'h0);
    chk("arst_en", 32'(gpio_en), 32'h0);
    chk("arst_lat", 32'(gpio_ilat), 32'h0);
    chk("arst_irq", 32'(gpio_irq), 32'h0);
    chk("arst_rdata", reg_rdata, 32'h0);
    repeat (2) @(negedge clk);
    reg_access = 1'b0;
    nreset = 1'b1;
    // level-low is the reset interrupt mode, so every idle-low pin latches again
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v);
      chk($sformatf("post_rst_rd%0d", i), v, (i == 9) ? 32'hFFFFFF : 32'h0);
    end
    chk("post_rst_irq", 32'(gpio_irq), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
